// File: rtl/gf163_pkg.sv
// Shared GF(2^163) definitions for the ECC datapath.
package gf163_pkg;

  localparam int unsigned GF_M = 163;

  typedef logic [GF_M-1:0] gf_elem_t;

  // Addition in a binary field is carry-free.
  function automatic gf_elem_t gf_add(input gf_elem_t a, input gf_elem_t b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    logic found;
    int   cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/gf_add_arbiter.sv
// Round-robin share of one GF(2^163) adder with a single-entry tagged output stage.
// Optional accumulate mode under GF_ADD_ACC_EN (adds REQ_ACC, ACC_CLR and an ACC register).
module gf_add_arbiter
  import gf163_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int M    = GF_M,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*M-1:0] REQ_A,
  input  logic [NREQ*M-1:0] REQ_B,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [M-1:0]      RSP_R
`ifdef GF_ADD_ACC_EN
  ,
  input  logic [NREQ-1:0]   REQ_ACC,
  input  logic              ACC_CLR
`endif
);

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [M-1:0]    rsp_r_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_nxt;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            arb_en;
  logic            transfer;
  logic [M-1:0]    a_sel;
  logic [M-1:0]    b_sel;
  logic [M-1:0]    sum;

  // Stage accepts when empty or draining this edge; reset forces all grants low.
  assign arb_en = (~rsp_valid_q | RSP_READY) & ~RST;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign REQ_READY = gnt;
  assign transfer  = |gnt;
  assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign a_sel     = REQ_A[gnt_idx*M +: M];

`ifdef GF_ADD_ACC_EN
  logic [M-1:0] acc_q;

  assign b_sel = REQ_ACC[gnt_idx] ? acc_q : REQ_B[gnt_idx*M +: M];

  // Clear wins over a same-edge load; the result on that edge still sees the old value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
    end else if (ACC_CLR) begin
      acc_q <= '0;
    end else if (transfer) begin
      acc_q <= sum;
    end
  end
`else
  assign b_sel = REQ_B[gnt_idx*M +: M];
`endif

  assign sum = M'(gf_add(gf_elem_t'(a_sel), gf_elem_t'(b_sel)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_r_q     <= '0;
      ptr_q       <= '0;
    end else if (transfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_idx;
      rsp_r_q     <= sum;
      ptr_q       <= ptr_nxt;
    end else if (RSP_READY) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_R     = rsp_r_q;

endmodule

// File: tb/tb_gf_add_arbiter.sv
// Scoreboard bench for gf_add_arbiter: directed grants queue expected results, a monitor checks them.
module tb_gf_add_arbiter;

  localparam int NREQ = 4;
  localparam int M    = 163;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [M-1:0]   r;
  } exp_t;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ*M-1:0] REQ_A;
  logic [NREQ*M-1:0] REQ_B;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [IDW-1:0]    RSP_ID;
  logic [M-1:0]      RSP_R;
`ifdef GF_ADD_ACC_EN
  logic [NREQ-1:0]   REQ_ACC;
  logic              ACC_CLR;
`endif

  gf_add_arbiter #(
    .NREQ (NREQ),
    .M    (M),
    .IDW  (IDW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_R     (RSP_R)
`ifdef GF_ADD_ACC_EN
    ,
    .REQ_ACC   (REQ_ACC),
    .ACC_CLR   (ACC_CLR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  // Hand-computed A ^ B per requester.
  logic [M-1:0] e0, e1, e2, e3;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [IDW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = IDW'(i);
    return r;
  endfunction

  // Drive one cycle, check the combinational grant, queue the expected result.
  task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic [NREQ-1:0] er,
                      input logic [M-1:0] xr);
    exp_t e;
    REQ_VALID = v;
    RSP_READY = rdy;
    @(negedge CLK);
    chk("req_ready", M'(REQ_READY), M'(er));
    if (er != '0) begin
      e.id = oh2idx(er);
      e.r  = xr;
      sb_q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: a result is consumed on the edge after RSP_VALID & RSP_READY.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && RSP_VALID && RSP_READY) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got id %0d r %0h, expected none", RSP_ID, RSP_R);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_id", M'(RSP_ID), M'(e.id));
        chk("rsp_r", RSP_R, e.r);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    e0 = 163'h6;
    e1 = 163'hFF0;
    e2 = (163'h1 << 162) | 163'h1;
    e3 = 163'hFFFF;
    REQ_A = '0;
    REQ_B = '0;
    REQ_A[0*M +: M] = 163'h5;    REQ_B[0*M +: M] = 163'h3;
    REQ_A[1*M +: M] = 163'hF00;  REQ_B[1*M +: M] = 163'h0F0;
    REQ_A[2*M +: M] = 163'h1 << 162;
    REQ_B[2*M +: M] = 163'h1;
    REQ_A[3*M +: M] = 163'hAAAA; REQ_B[3*M +: M] = 163'h5555;
`ifdef GF_ADD_ACC_EN
    REQ_ACC = '0;
    ACC_CLR = 1'b0;
`endif
    RST       = 1'b1;
    REQ_VALID = 4'b1111;
    RSP_READY = 1'b1;

    // Reset state, grants suppressed while RST is high.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_ready", M'(REQ_READY), '0);
    chk("rst_rsp_valid", M'(RSP_VALID), '0);
    chk("rst_rsp_id", M'(RSP_ID), '0);
    chk("rst_rsp_r", RSP_R, '0);
    RST = 1'b0;

    // Single request from requester 0.
    step(4'b0001, 1'b1, 4'b0001, e0);
    step(4'b0000, 1'b1, 4'b0000, '0);

    // Grant requester 2, hold it in the stage, then reset mid-flight.
    step(4'b0100, 1'b1, 4'b0100, e2);
    step(4'b0000, 1'b0, 4'b0000, '0);
    chk("held_rsp_valid", M'(RSP_VALID), 163'h1);
    REQ_VALID = 4'b1111;
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_valid", M'(RSP_VALID), '0);
    chk("async_rst_r", RSP_R, '0);
    chk("async_rst_id", M'(RSP_ID), '0);
    chk("async_rst_ready", M'(REQ_READY), '0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // All requesters valid: grants rotate 0,1,2,3,0.
    step(4'b1111, 1'b1, 4'b0001, e0);
    step(4'b1111, 1'b1, 4'b0010, e1);
    step(4'b1111, 1'b1, 4'b0100, e2);
    step(4'b1111, 1'b1, 4'b1000, e3);
    step(4'b1111, 1'b1, 4'b0001, e0);

    // Backpressure: no grants, output stage holds.
    for (int i = 0; i < 3; i++) begin
      REQ_VALID = 4'b1111;
      RSP_READY = 1'b0;
      @(negedge CLK);
      chk("stall_ready", M'(REQ_READY), '0);
      chk("stall_valid", M'(RSP_VALID), 163'h1);
      chk("stall_id", M'(RSP_ID), '0);
      chk("stall_r", RSP_R, e0);
      @(posedge CLK);
      #1;
    end
    // Release: drain and refill on the same edge.
    step(4'b1111, 1'b1, 4'b0010, e1);
    step(4'b0000, 1'b1, 4'b0000, '0);

    // Wrap: grant 2 moves the pointer to 3, then 0101 wraps to 0, then 2.
    step(4'b0100, 1'b1, 4'b0100, e2);
    step(4'b0101, 1'b1, 4'b0001, e0);
    step(4'b0101, 1'b1, 4'b0100, e2);
    step(4'b0000, 1'b1, 4'b0000, '0);
    chk("idle_valid", M'(RSP_VALID), '0);
    chk("idle_hold_id", M'(RSP_ID), 163'h2);
    chk("idle_hold_r", RSP_R, e2);

`ifdef GF_ADD_ACC_EN
    REQ_A[0*M +: M] = 163'hF0;
    REQ_B[0*M +: M] = '0;
    REQ_ACC = 4'b0000;
    step(4'b0001, 1'b1, 4'b0001, 163'hF0);
    REQ_A[0*M +: M] = 163'h0F;
    REQ_ACC = 4'b0001;
    step(4'b0001, 1'b1, 4'b0001, 163'hFF);
    ACC_CLR = 1'b1;
    step(4'b0000, 1'b1, 4'b0000, '0);
    ACC_CLR = 1'b0;
    REQ_A[0*M +: M] = 163'h1;
    step(4'b0001, 1'b1, 4'b0001, 163'h1);
    REQ_ACC = 4'b0000;
    step(4'b0000, 1'b1, 4'b0000, '0);
`endif

    repeat (3) step(4'b0000, 1'b1, 4'b0000, '0);
    chk("sb_empty", M'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
